salu_arbiter: RTL

Shares the single registered scalar ALU (`salu`) between `NUM_REQ` requesters, e.g. scalar issue and the vector unit's scalar-operand path. Requesters are served round-robin with a one-operation-in-flight policy. Each requester gets a valid/ready request port and a valid/ready response channel. The block sits between the requesters and the ALU's operand/opcode inputs, and it captures the ALU's registered result and flags for return to the granted requester.

---
 rtl/salu_arbiter_if.sv | 38 +++
 rtl/salu_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/salu_arbiter_if.sv
// Requester and ALU-side bundle for salu_arbiter; the arbiter takes the slave
// modport, the requesters/ALU environment takes the master modport.
interface salu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rs1_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rs2_i;
  logic [NUM_REQ-1:0][3:0]            req_op_i;
  logic [NUM_REQ-1:0]                 rsp_valid_o;
  logic [NUM_REQ-1:0]                 rsp_ready_i;
  logic [DATA_WIDTH-1:0]              rsp_res_o;
  logic [2:0]                         rsp_flags_o;
  logic                               flush_i;
  logic [DATA_WIDTH-1:0]              alu_rs1_o;
  logic [DATA_WIDTH-1:0]              alu_rs2_o;
  logic [3:0]                         alu_op_o;
  logic [DATA_WIDTH-1:0]              alu_res_i;
  logic                               alu_zero_i;
  logic                               alu_neg_i;
  logic                               alu_ovf_i;

  modport slave (
    input  req_valid_i, req_rs1_i, req_rs2_i, req_op_i, rsp_ready_i, flush_i,
           alu_res_i, alu_zero_i, alu_neg_i, alu_ovf_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_flags_o,
           alu_rs1_o, alu_rs2_o, alu_op_o
  );

  modport master (
    output req_valid_i, req_rs1_i, req_rs2_i, req_op_i, rsp_ready_i, flush_i,
           alu_res_i, alu_zero_i, alu_neg_i, alu_ovf_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_flags_o,
           alu_rs1_o, alu_rs2_o, alu_op_o
  );
endinterface

// File: rtl/salu_arbiter.sv
// Round-robin, one-op-in-flight arbiter sharing a registered scalar ALU between
// NUM_REQ requesters; captures the ALU result/flags and returns them to the owner.
module salu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  salu_arbiter_if.slave      bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      grant;
  logic [NUM_REQ-1:0]    above_last;
  logic [NUM_REQ-1:0]    masked_valid;
  logic                  owner_ack;
  logic                  issue;
  logic [DATA_WIDTH-1:0] res_buf;
  logic [2:0]            flags_buf;

  // Requesters above last_grant take priority; otherwise wrap to the lowest index.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_last[i] = (IDX_W'(i) > last_grant);
    end
    masked_valid = bus.req_valid_i & above_last;
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) grant = IDX_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked_valid[i]) grant = IDX_W'(i);
    end
  end

  assign owner_ack = bus.rsp_ready_i[owner];

  // Reset gating keeps req_ready/alu_* at zero while rst_n is held low.
  assign issue = rst_n && !bus.flush_i && (|bus.req_valid_i) &&
                 ((state == IDLE) || ((state == RESP) && owner_ack));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = WAIT;
      WAIT: state_next = bus.flush_i ? IDLE : RESP;
      RESP: begin
        if (bus.flush_i)    state_next = IDLE;
        else if (owner_ack) state_next = issue ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.alu_rs1_o   = '0;
    bus.alu_rs2_o   = '0;
    bus.alu_op_o    = '0;
    if (issue) begin
      bus.req_ready_o[grant] = 1'b1;
      bus.alu_rs1_o          = bus.req_rs1_i[grant];
      bus.alu_rs2_o          = bus.req_rs2_i[grant];
      bus.alu_op_o           = bus.req_op_i[grant];
    end
    if ((state == RESP) && !bus.flush_i) begin
      bus.rsp_valid_o[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The ALU result is valid in WAIT, one cycle after the operands were issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      res_buf    <= '0;
      flags_buf  <= '0;
    end else begin
      if (issue) begin
        owner      <= grant;
        last_grant <= grant;
      end
      if ((state == WAIT) && !bus.flush_i) begin
        res_buf   <= bus.alu_res_i;
        flags_buf <= {bus.alu_ovf_i, bus.alu_neg_i, bus.alu_zero_i};
      end
    end
  end

  assign bus.rsp_res_o   = res_buf;
  assign bus.rsp_flags_o = flags_buf;

endmodule
